spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 269 ++++++++++++++++++++++++++
 tb/tb_spi_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`timescale 1ns/1ps
// spi_master: single-slave SPI master sending an 11-bit command frame
// (lead bit, 2-bit cmd, 8-bit payload). A read-data frame (cmd=11) adds
// TA_CYCLES turnaround SCK periods and then receives one byte from MISO.
// SCK idles low. MOSI changes on the clk edge that drives SCK low.
// MISO is sampled on the clk edge that drives SCK high->low.
//
// Handshake: start is honoured only in IDLE and only when done is low.
// busy stays high until the cycle in which done pulses. There is no
// ready/valid backpressure and no queuing of a start.
//
// Optional feature: define SPI_MASTER_ABORT_EN to add the abort input and
// the aborted output. abort in SETUP/SHIFT/TURN/READ forces SCK low and
// goes to HOLD. The closing done then pulses with aborted=1.
//
// dbg_state exposes the FSM state so checkers can bind to it.
module spi_master #(
  parameter int CLK_DIV   = 2,
  parameter int TA_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
`ifdef SPI_MASTER_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       SCK,
  output logic       MOSI,
  output logic       SS_n,
  input  logic       MISO,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_TURN  = 3'd3,
    S_READ  = 3'd4,
    S_HOLD  = 3'd5
  } state_e;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [15:0]   TURN_LAST  = 16'(TA_CYCLES - 1);
  localparam logic [15:0]   SHIFT_LAST = 16'd10;
  localparam logic [15:0]   READ_LAST  = 16'd7;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;       // half-period divider
  logic [15:0]   cnt_q, cnt_d;       // SCK falling edges within the current state
  logic [9:0]    tx_q, tx_d;         // bits still to be placed on MOSI
  logic [6:0]    rx_q, rx_d;         // first seven received bits
  logic [7:0]    rdata_q, rdata_d;
  logic          rd_frame_q, rd_frame_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          ss_n_q, ss_n_d;
  logic          done_q, done_d;
  logic          tick;               // last clk cycle of a half-period
  logic          sck_fall;           // this edge drives SCK high->low
  logic          accept;             // start honoured this cycle
  logic          abort_hit;          // abort honoured this cycle
`ifdef SPI_MASTER_ABORT_EN
  logic          abrt_pend_q, abrt_pend_d;
  logic          aborted_q, aborted_d;
`endif

  assign tick     = (div_q == DIV_LAST);
  assign sck_fall = tick && sck_q;
  assign accept   = (state_q == S_IDLE) && start && !done_q;

  // abort qualification: only active frame states react to it
  always_comb begin
    abort_hit = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    abort_hit = abort && ((state_q == S_SETUP) || (state_q == S_SHIFT) ||
                          (state_q == S_TURN)  || (state_q == S_READ));
`endif
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_SETUP;
      S_SETUP: begin
        if (abort_hit) state_d = S_HOLD;
        else if (tick) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort_hit) begin
          state_d = S_HOLD;
        end else if (sck_fall && cnt_q == SHIFT_LAST) begin
          if (!rd_frame_q)         state_d = S_HOLD;
          else if (TA_CYCLES == 0) state_d = S_READ;
          else                     state_d = S_TURN;
        end
      end
      S_TURN: begin
        if (abort_hit)                            state_d = S_HOLD;
        else if (sck_fall && cnt_q == TURN_LAST)  state_d = S_READ;
      end
      S_READ: begin
        if (abort_hit)                            state_d = S_HOLD;
        else if (sck_fall && cnt_q == READ_LAST)  state_d = S_HOLD;
      end
      S_HOLD:  if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // next values of the datapath and the registered pin outputs
  always_comb begin
    div_d      = (state_q == S_IDLE || tick) ? '0 : div_q + DW'(1);
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rdata_d    = rdata_q;
    rd_frame_d = rd_frame_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    done_d     = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    abrt_pend_d = abrt_pend_q;
    aborted_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        ss_n_d = 1'b1;
        if (accept) begin
          // the lead bit goes out at once; the rest waits in tx
          tx_d       = {cmd, wdata};
          mosi_d     = cmd[1];
          ss_n_d     = 1'b0;
          rd_frame_d = (cmd == 2'b11);
          cnt_d      = '0;
`ifdef SPI_MASTER_ABORT_EN
          abrt_pend_d = 1'b0;
`endif
        end
      end
      S_SETUP: begin
        sck_d = 1'b0;
      end
      S_SHIFT: begin
        if (tick) sck_d = ~sck_q;
        if (sck_fall) begin
          if (cnt_q == SHIFT_LAST) begin
            cnt_d  = '0;
            mosi_d = 1'b0;
          end else begin
            cnt_d  = cnt_q + 16'd1;
            mosi_d = tx_q[9];
            tx_d   = {tx_q[8:0], 1'b0};
          end
        end
      end
      S_TURN: begin
        if (tick) sck_d = ~sck_q;
        if (sck_fall) cnt_d = (cnt_q == TURN_LAST) ? '0 : cnt_q + 16'd1;
      end
      S_READ: begin
        if (tick) sck_d = ~sck_q;
        if (sck_fall) begin
          rx_d = {rx_q[5:0], MISO};
          if (cnt_q == READ_LAST) begin
            cnt_d   = '0;
            rdata_d = {rx_q, MISO};
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_HOLD: begin
        sck_d = 1'b0;
        if (tick) begin
          ss_n_d = 1'b1;
          done_d = 1'b1;
`ifdef SPI_MASTER_ABORT_EN
          aborted_d = abrt_pend_q;
`endif
        end
      end
      default: begin
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        ss_n_d = 1'b1;
      end
    endcase
    // an abort parks the bus and leaves rdata untouched
    if (abort_hit) begin
      sck_d   = 1'b0;
      mosi_d  = 1'b0;
      cnt_d   = '0;
      div_d   = '0;
      rdata_d = rdata_q;
`ifdef SPI_MASTER_ABORT_EN
      abrt_pend_d = 1'b1;
`endif
    end
  end

  // datapath and pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      cnt_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rdata_q    <= 8'h00;
      rd_frame_q <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rdata_q    <= rdata_d;
      rd_frame_q <= rd_frame_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      done_q     <= done_d;
    end
  end

`ifdef SPI_MASTER_ABORT_EN
  // abort bookkeeping: remembered until the closing done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abrt_pend_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      abrt_pend_q <= abrt_pend_d;
      aborted_q   <= aborted_d;
    end
  end

  assign aborted = aborted_q;
`endif

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign SCK       = sck_q;
  assign MOSI      = mosi_q;
  assign SS_n      = ss_n_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
// tb_spi_master: random frames against a transaction-level register-file
// model. A pin-level slave (RAM behind the SPI bus) answers read-data
// frames. A monitor pops one expected record per done pulse and compares
// it with what was seen on the pins.
// Define SPI_MASTER_ABORT_EN to also exercise the abort feature.
module tb_spi_master;
  localparam int CLK_DIV = 2;
  localparam int TA      = 2;
  localparam int W       = 27;   // {sck pulses[7:0], mosi bits[10:0], rdata[7:0]}

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] wdata = 8'h00;
  logic       MISO = 1'b0;
  logic       busy, done, SCK, MOSI, SS_n;
  logic [7:0] rdata;
  logic [2:0] dbg_state;
`ifdef SPI_MASTER_ABORT_EN
  logic       abort = 1'b0;
  logic       aborted;
  bit         abort_exp = 1'b0;
  int         n_abort_seen = 0;
`endif

  spi_master #(.CLK_DIV(CLK_DIV), .TA_CYCLES(TA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .wdata(wdata),
`ifdef SPI_MASTER_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .rdata(rdata), .SCK(SCK), .MOSI(MOSI),
    .SS_n(SS_n), .MISO(MISO), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // transaction-level reference: one address pointer and a 256-byte store
  logic [7:0] ref_ram [256] = '{default: 8'h00};
  logic [7:0] ref_addr  = 8'h00;
  logic [7:0] ref_rdata = 8'h00;

  // pin-level slave and observation of the bus
  logic [7:0] sl_ram [256] = '{default: 8'h00};
  logic [7:0] sl_addr = 8'h00;
  logic [7:0] sl_out  = 8'h00;
  int         mon_sck = 0;
  logic [10:0] mon_bits = '0;
  int         mon_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // slave: samples MOSI on SCK rise, drives MISO after SCK rise
  always @(posedge SCK or negedge SS_n) begin
    if (SCK) begin
      mon_sck = mon_sck + 1;
      if (mon_sck <= 11) mon_bits = {mon_bits[9:0], MOSI};
      else if (MOSI !== 1'b0) mon_bad = mon_bad + 1;
      if (mon_sck == 11) begin
        case (mon_bits[9:8])
          2'b00: sl_addr = mon_bits[7:0];
          2'b01: sl_ram[sl_addr] = mon_bits[7:0];
          2'b10: sl_addr = mon_bits[7:0];
          default: sl_out = sl_ram[sl_addr];
        endcase
      end
      if (mon_sck >= 12 + TA && mon_sck <= 19 + TA)
        MISO = sl_out[7 - (mon_sck - 12 - TA)];
    end else begin
      mon_sck  = 0;
      mon_bits = '0;
      mon_bad  = 0;
      MISO     = 1'b0;
    end
  end

  // scoreboard monitor: one expected record per done pulse
  always @(negedge clk) begin
    if (rst_n && done) begin
`ifdef SPI_MASTER_ABORT_EN
      if (aborted) begin
        n_abort_seen++;
        check("abort_expected", {31'b0, abort_exp}, 32'd1);
        check("abort_rdata_kept", {24'b0, rdata}, {24'b0, ref_rdata});
      end else
`endif
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("frame", {5'b0, 8'(mon_sck), mon_bits, rdata}, {5'b0, e});
        check("mosi_zero_after_cmd", mon_bad, 0);
        check("ss_n_after_done", {31'b0, SS_n}, 32'd1);
        check("busy_low_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic wait_idle(input int budget);
    int i = 0;
    while ((busy || done) && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (i >= budget) check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] w, input bit push);
    int sck;
    logic [7:0] er;
    wait_idle(400);
    cmd = c;
    wdata = w;
    start = 1'b1;
    if (push) begin
      sck = (c == 2'b11) ? 11 + TA + 8 : 11;
      er = ref_rdata;
      case (c)
        2'b00: ref_addr = w;
        2'b01: ref_ram[ref_addr] = w;
        2'b10: ref_addr = w;
        default: begin
          er = ref_ram[ref_addr];
          ref_rdata = er;
        end
      endcase
      exp_q.push_back({8'(sck), c[1], c, w, er});
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    cmd = 2'($urandom);
    wdata = 8'($urandom);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss_n", {31'b0, SS_n}, 32'd1);
    check("rst_sck", {31'b0, SCK}, 32'd0);
    check("rst_mosi", {31'b0, MOSI}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_rdata", {24'b0, rdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed frames: A5 write-address, read of 3C, register-file sequence
    send(2'b00, 8'hA5, 1'b1);
    send(2'b00, 8'h20, 1'b1);
    send(2'b01, 8'h3C, 1'b1);
    send(2'b11, 8'hFF, 1'b1);
    send(2'b00, 8'h10, 1'b1);
    send(2'b01, 8'h77, 1'b1);
    send(2'b10, 8'h10, 1'b1);
    send(2'b11, 8'h00, 1'b1);

    // random frames, some with an extra start pulsed mid-frame
    for (int n = 0; n < 40; n++) begin
      send(2'($urandom), 8'($urandom_range(0, 15)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(2, 30)) @(negedge clk);
        cmd = 2'($urandom);
        start = 1'b1;
        check("busy_mid_frame", {31'b0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
      end
    end

    // start in the done cycle is ignored, one cycle later it is accepted
    begin
      int i = 0;
      while (!done && i < 400) begin
        @(negedge clk);
        i++;
      end
      check("done_seen", {31'b0, done}, 32'd1);
      start = 1'b1;
      cmd = 2'b10;
      @(negedge clk);
      start = 1'b0;
      check("start_on_done_ignored", {31'b0, busy}, 32'd0);
      send(2'b11, 8'h5A, 1'b1);
    end

    // reset during bit 5 of SHIFT, then a clean read frame
    wait_idle(400);
    send(2'b01, 8'($urandom), 1'b0);
    begin
      int i = 0;
      while (mon_sck < 5 && i < 100) begin
        @(negedge clk);
        i++;
      end
      check("reached_bit5", mon_sck, 5);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_ss_n", {31'b0, SS_n}, 32'd1);
    check("arst_sck", {31'b0, SCK}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_rdata", {24'b0, rdata}, 32'd0);
    ref_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(2'b11, 8'h00, 1'b1);
    send(2'b00, 8'hA5, 1'b1);

`ifdef SPI_MASTER_ABORT_EN
    // abort after three READ samples
    wait_idle(400);
    abort_exp = 1'b1;
    send(2'b11, 8'h00, 1'b0);
    begin
      int i = 0;
      while (!(mon_sck == 14 + TA && !SCK) && i < 200) begin
        @(negedge clk);
        i++;
      end
      check("reached_read3", mon_sck, 14 + TA);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("sck_low_after_abort", {31'b0, SCK}, 32'd0);
    wait_idle(400);
    @(negedge clk);
    check("abort_done_count", n_abort_seen, 1);
    abort_exp = 1'b0;
    send(2'b11, 8'h00, 1'b1);
`endif

    wait_idle(400);
    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
